ula_seq: RTL

//  Parametrised multi-cycle unsigned ALU for the expression solver: ADD, SUB, MUL, DIV on WIDTH-bit operands.

---
 rtl/ula_pkg.sv | 14 +
 rtl/ula_muldiv_step.sv | 26 ++
 rtl/ula_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: opcode encodings, FSM state type and a counter-width helper for ula_seq
package ula_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ula_muldiv_step.sv
// ula_muldiv_step: one combinational iteration of shift-add multiply or restoring divide
//   div_mode in  1     0: multiply step, 1: divide step
//   acc      in  2W    MUL {partial product, remaining multiplier}; DIV {partial remainder, dividend/quotient}
//   d        in  W     multiplicand (MUL) or divisor (DIV)
//   acc_nxt  out 2W    accumulator after one iteration
module ula_muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic                 div_mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     d,
  output logic [2*WIDTH-1:0]   acc_nxt
);
  logic [WIDTH:0] sum, trial, diff;
  logic           ge;
  always_comb begin
    // multiply: add multiplicand on the low multiplier bit, then shift the whole accumulator right
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
    // divide: shift the next dividend bit into the partial remainder and trial-subtract
    trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = trial - {1'b0, d};
    ge      = trial >= {1'b0, d};
    acc_nxt = div_mode ? {ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0], acc[WIDTH-2:0], ge}
                       : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/ula_seq.sv
// ula_seq: multi-cycle unsigned ALU (ADD/SUB single cycle, MUL/DIV iterative) with valid/ready handshakes
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operation handshake; op, a, b captured on transfer
//   out_valid/out_ready   result handshake; result, remainder, ovf, dz held while out_valid
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             ovf,
  output logic             dz
);
  localparam int CW = clog2(WIDTH + 1);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   d_q, d_d, result_q, result_d, rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step;
  logic               ovf_q, ovf_d, dz_q, dz_d;
  logic [WIDTH:0]     add_s, sub_s;
  ula_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (op_q == OP_DIV),
    .acc      (acc_q),
    .d        (d_q),
    .acc_nxt  (step)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      d_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      d_q      <= d_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end
  always_comb begin
    add_s    = {1'b0, a} + {1'b0, b};
    sub_s    = {1'b0, a} - {1'b0, b};
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    d_d      = d_q;
    acc_d    = acc_q;
    result_d = result_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    if (state_q == ST_IDLE && in_valid) begin
      op_d     = op;
      cnt_d    = '0;
      state_d  = (op == OP_MUL || (op == OP_DIV && b != '0)) ? ST_CALC : ST_DONE;
      d_d      = op == OP_MUL ? a : b;
      acc_d    = {{WIDTH{1'b0}}, op == OP_MUL ? b : a};
      // ADD/SUB and divide-by-zero finish here; MUL/DIV overwrite these on the last iteration
      result_d = op == OP_ADD ? add_s[WIDTH-1:0] : op == OP_SUB ? sub_s[WIDTH-1:0] : '1;
      rem_d    = op == OP_DIV ? a : '0;
      ovf_d    = op == OP_ADD ? add_s[WIDTH] : op == OP_SUB ? sub_s[WIDTH] : 1'b0;
      dz_d     = op == OP_DIV && b == '0;
    end else if (state_q == ST_CALC) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d  = ST_DONE;
        result_d = step[WIDTH-1:0];
        rem_d    = op_q == OP_DIV ? step[2*WIDTH-1:WIDTH] : '0;
        ovf_d    = op_q == OP_MUL && |step[2*WIDTH-1:WIDTH];
      end
    end else if (state_q == ST_DONE && out_ready) begin
      state_d = ST_IDLE;
    end
  end
  always_comb begin
    in_ready  = state_q == ST_IDLE;
    out_valid = state_q == ST_DONE;
    result    = result_q;
    remainder = rem_q;
    ovf       = ovf_q;
    dz        = dz_q;
  end
endmodule
